// File: rtl/fifo_lib_pkg.sv
// Shared types and helpers for the FWFT FIFO family.
// Holds the serializer state encoding, the width-ratio helper and the
// default widths used by fwft_word_serializer.
package fifo_lib_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_t;

    localparam int DEF_IN_WIDTH  = 32;
    localparam int DEF_OUT_WIDTH = 8;

    // Number of output beats needed to carry one input word.
    function automatic int ser_ratio(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

endpackage : fifo_lib_pkg

// File: rtl/fwft_word_serializer.sv
// fwft_word_serializer: pops wide words from a show-ahead (FWFT) FIFO and
// streams them out as OUT_WIDTH sub-words over a valid/ready handshake.
// The next word is popped on the same cycle as the last beat of the
// current one is accepted, so back-to-back words leave no bubble.
// Optional build macro: SERIALIZER_STATS_EN adds word_count/stall_count.
module fwft_word_serializer
    import fifo_lib_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  fifo_rd_data,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
`ifdef SERIALIZER_STATS_EN
    output logic [31:0]          word_count,
    output logic [31:0]          stall_count,
`endif
    output logic                 busy
);

    localparam int RATIO = ser_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    if (((IN_WIDTH % OUT_WIDTH) != 0) || (RATIO < 2)) begin : g_param_check
        $error("fwft_word_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
    end

    ser_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]  word_q, word_d;

    logic                 sending;
    logic                 last_beat;
    logic                 accept;
    logic                 pop;
    logic [OUT_WIDTH-1:0] sub_w [RATIO];

    // Slice the held word into beats in transmission order.
    for (genvar g = 0; g < RATIO; g++) begin : g_slice
        if (MSB_FIRST != 0) begin : g_msb
            assign sub_w[g] = word_q[IN_WIDTH-1-g*OUT_WIDTH -: OUT_WIDTH];
        end else begin : g_lsb
            assign sub_w[g] = word_q[g*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    assign sending   = (state_q == S_SEND);
    assign last_beat = (cnt_q == LAST_CNT);
    assign accept    = sending && out_ready;

    // Pop from idle, or on the last-beat accept for zero-bubble reload.
    // Gated by rst so the FIFO never advances while reset is held.
    assign pop = !rst && !fifo_empty && (!sending || (accept && last_beat));

    assign fifo_rd_en = pop;
    assign out_valid  = sending;
    assign busy       = sending;
    assign out_last   = sending && last_beat;
    assign out_data   = sending ? sub_w[cnt_q] : '0;

    // Next-state logic: load a new word on pop, otherwise step through beats.
    always_comb begin
        // NOTE: every target gets a default first so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        if (pop) begin
            word_d  = fifo_rd_data;
            cnt_d   = '0;
            state_d = S_SEND;
        end else if (accept) begin
            if (last_beat) begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State, beat counter and held word; cleared asynchronously on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

`ifdef SERIALIZER_STATS_EN
    logic [31:0] word_count_q;
    logic [31:0] stall_count_q;

    // Free-running statistics; both wrap modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count_q  <= '0;
            stall_count_q <= '0;
        end else begin
            if (pop) begin
                word_count_q <= word_count_q + 32'd1;
            end
            if (sending && !out_ready) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign word_count  = word_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule : fwft_word_serializer
